// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer with run-time loadable primary/CB dispatch tables, micro-call stack and memory-wait stalls.
// Optional feature macro DZCPU_USEQ_PERF_EN adds oFlowCycles (saturating accept-to-EOF cycle count of the last flow).
module dzcpu_useq #(
    parameter int UADDR_W     = 8,
    parameter int PAYLOAD_W   = 10,
    parameter int FLOW_W      = 3,
    parameter int STACK_DEPTH = 2
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic [7:0]                  iMop,
    input  logic                        iMopValid,
    output logic                        oMopReady,
    output logic [UADDR_W-1:0]          oUaddr,
    input  logic [FLOW_W+PAYLOAD_W-1:0] iUword,
    input  logic                        iCond,
    input  logic                        iMemAck,
    input  logic                        iTblWe,
    input  logic                        iTblSel,
    input  logic [7:0]                  iTblAddr,
    input  logic [UADDR_W-1:0]          iTblData,
    output logic [PAYLOAD_W-1:0]        oUop,
    output logic                        oUopValid,
    output logic                        oEof,
    output logic                        oUerr
`ifdef DZCPU_USEQ_PERF_EN
    ,
    output logic [15:0]                 oFlowCycles
`endif
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {S_FETCH, S_RUN, S_CBWAIT, S_STALL} state_t;
    typedef enum logic [2:0] {
        F_NEXT, F_EOF, F_EOF_IF, F_JCB, F_CALL, F_RET, F_WAIT, F_BAD
    } flow_t;

    logic [UADDR_W-1:0]   primary_tbl [256];
    logic [UADDR_W-1:0]   cb_tbl      [256];
    logic [UADDR_W-1:0]   ret_stack   [2**IDX_W];

    state_t               state, state_next;
    logic [UADDR_W-1:0]   upc, upc_next, upc_inc, ret_addr;
    logic [SP_W-1:0]      sp, sp_next, sp_dec;
    logic                 push, issue, eof, err_set;
    flow_t                flow;
    logic [PAYLOAD_W-1:0] payload;

    assign flow     = flow_t'(iUword[FLOW_W+PAYLOAD_W-1 -: FLOW_W]);
    assign payload  = iUword[PAYLOAD_W-1:0];
    assign upc_inc  = upc + UADDR_W'(1);
    assign sp_dec   = sp - SP_W'(1);
    assign ret_addr = ret_stack[sp_dec[IDX_W-1:0]];
    assign oUaddr   = upc;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        upc_next   = upc;
        sp_next    = sp;
        push       = 1'b0;
        issue      = 1'b0;
        eof        = 1'b0;
        err_set    = 1'b0;
        oMopReady  = 1'b0;
        case (state)
            S_FETCH, S_CBWAIT: begin
                oMopReady = 1'b1;
                if (iMopValid) begin
                    upc_next   = (state == S_FETCH) ? primary_tbl[iMop] : cb_tbl[iMop];
                    state_next = S_RUN;
                end
            end
            S_STALL: begin
                if (iMemAck) begin
                    upc_next   = upc_inc;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                issue    = 1'b1;
                upc_next = upc_inc;
                case (flow)
                    F_NEXT: ;
                    F_EOF: begin
                        eof        = 1'b1;
                        state_next = S_FETCH;
                    end
                    F_EOF_IF: begin
                        if (iCond) begin
                            eof        = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    F_JCB: state_next = S_CBWAIT;
                    F_CALL: begin
                        upc_next = payload[UADDR_W-1:0];
                        // A full stack drops the return address but still takes the jump.
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            err_set = 1'b1;
                        end else begin
                            push    = 1'b1;
                            sp_next = sp + SP_W'(1);
                        end
                    end
                    F_RET: begin
                        if (sp == '0) begin
                            err_set    = 1'b1;
                            eof        = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            upc_next = ret_addr;
                            sp_next  = sp_dec;
                        end
                    end
                    F_WAIT: begin
                        if (!iMemAck) begin
                            upc_next   = upc;
                            state_next = S_STALL;
                        end
                    end
                    default: err_set = 1'b1;
                endcase
            end
            default: state_next = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the dispatch read above sees the old table entry on a same-cycle write.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state     <= S_FETCH;
            upc       <= '0;
            sp        <= '0;
            oUop      <= '0;
            oUopValid <= 1'b0;
            oEof      <= 1'b0;
            oUerr     <= 1'b0;
            for (int i = 0; i < 256; i++) begin
                primary_tbl[i] <= '0;
                cb_tbl[i]      <= '0;
            end
        end else begin
            state     <= state_next;
            upc       <= upc_next;
            sp        <= sp_next;
            oUopValid <= issue;
            oEof      <= eof;
            if (issue)   oUop  <= payload;
            if (err_set) oUerr <= 1'b1;
            if (iTblWe) begin
                if (iTblSel) cb_tbl[iTblAddr]      <= iTblData;
                else         primary_tbl[iTblAddr] <= iTblData;
            end
        end
    end

    // NOTE: stack storage is not reset; resetting sp alone makes every entry dead.
    always_ff @(posedge iClock) begin
        if (push) ret_stack[sp[IDX_W-1:0]] <= upc_inc;
    end

`ifdef DZCPU_USEQ_PERF_EN
    logic [15:0] flow_cnt;

    // flow_cnt counts the current cycle's predecessors within the flow, starting at the accept cycle.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            flow_cnt    <= '0;
            oFlowCycles <= '0;
        end else begin
            if (state == S_FETCH)           flow_cnt <= 16'd1;
            else if (flow_cnt != 16'hFFFF)  flow_cnt <= flow_cnt + 16'd1;
            if (eof) oFlowCycles <= (flow_cnt == 16'hFFFF) ? 16'hFFFF : flow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed scenarios plus randomized flows scored against a
// flow-level interpreter of the dispatch tables and ROM.
module tb_dzcpu_useq;

    localparam int DEPTH = 2;
    localparam logic [2:0] F_NEXT = 3'd0, F_EOF = 3'd1, F_EOF_IF = 3'd2, F_JCB = 3'd3,
                           F_CALL = 3'd4, F_RET = 3'd5, F_WAIT = 3'd6, F_BAD = 3'd7;

    logic        clk = 1'b0;
    logic        rst, mop_valid, cond, mem_ack, tbl_we, tbl_sel;
    logic [7:0]  mop, tbl_addr, tbl_data;
    logic [12:0] uword;
    wire         mop_ready, uop_valid, eof, uerr;
    wire  [7:0]  uaddr;
    wire  [9:0]  uop;

    logic [12:0] rom [256];
    assign uword = rom[uaddr];

    always #5 clk = ~clk;

    dzcpu_useq #(.UADDR_W(8), .PAYLOAD_W(10), .FLOW_W(3), .STACK_DEPTH(DEPTH)) dut (
        .iClock(clk), .iReset(rst), .iMop(mop), .iMopValid(mop_valid), .oMopReady(mop_ready),
        .oUaddr(uaddr), .iUword(uword), .iCond(cond), .iMemAck(mem_ack), .iTblWe(tbl_we),
        .iTblSel(tbl_sel), .iTblAddr(tbl_addr), .iTblData(tbl_data), .oUop(uop),
        .oUopValid(uop_valid), .oEof(eof), .oUerr(uerr)
    );

    // Reference model state
    logic [7:0]  prim_m [256];
    logic [7:0]  cb_m   [256];
    logic [7:0]  stk [$];
    logic [10:0] exp_q [$];
    logic [7:0]  op_q [$];
    bit          err_m;
    int          checks = 0, errors = 0, cyc = 0, got_n = 0;

    function automatic logic [12:0] mk(input logic [2:0] f, input logic [9:0] p);
        return {f, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            prim_m[i] = 8'd0;
            cb_m[i]   = 8'd0;
        end
        stk.delete();
        exp_q.delete();
        op_q.delete();
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; mop_valid = 1'b0; tbl_we = 1'b0; mem_ack = 1'b0; cond = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic tbl_write(input logic sel, input logic [7:0] addr, input logic [7:0] data);
        tbl_we = 1'b1; tbl_sel = sel; tbl_addr = addr; tbl_data = data;
        tick();
        tbl_we = 1'b0;
        if (sel) cb_m[addr] = data;
        else     prim_m[addr] = data;
    endtask

    // Interprets every opcode in op_q as a whole flow and appends {eof, payload} per executed microword.
    task automatic model_run();
        logic [7:0]  ops [$];
        logic [7:0]  pc, op;
        logic [12:0] w;
        logic [9:0]  p;
        bit          e;
        int          steps;
        ops = op_q;
        while (ops.size() > 0) begin
            op = ops.pop_front();
            pc = prim_m[op];
            e = 1'b0;
            steps = 0;
            while (!e && steps < 500) begin
                w = rom[pc];
                p = w[9:0];
                steps++;
                case (w[12:10])
                    F_NEXT, F_WAIT: pc = pc + 8'd1;
                    F_EOF:          e = 1'b1;
                    F_EOF_IF:       if (cond) e = 1'b1; else pc = pc + 8'd1;
                    F_JCB:          if (ops.size() > 0) begin op = ops.pop_front(); pc = cb_m[op]; end
                    F_CALL: begin
                        if (stk.size() < DEPTH) stk.push_back(pc + 8'd1);
                        else err_m = 1'b1;
                        pc = p[7:0];
                    end
                    F_RET:          if (stk.size() == 0) begin err_m = 1'b1; e = 1'b1; end
                                    else pc = stk.pop_back();
                    default: begin err_m = 1'b1; pc = pc + 8'd1; end
                endcase
                exp_q.push_back({e, p});
            end
        end
    endtask

    // Feeds op_q whenever the sequencer is ready and scores every issued uop against exp_q.
    task automatic run_ops(input int n_eofs, input bit rand_ack);
        int          eofs = 0, start = 0, budget = 0;
        bit          new_flow = 1'b1, await_first = 1'b0;
        logic [10:0] e;
        got_n = 0;
        while (eofs < n_eofs && budget < 400) begin
            if (uop_valid) begin
                got_n++;
                if (await_first) begin
                    checks++;
                    if (cyc - start != 2) begin
                        errors++;
                        $display("FAIL first_uop_latency got %0d cycles expected 2", cyc - start);
                    end
                    await_first = 1'b0;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_uop got eof=%0b uop=%h expected none", eof, uop);
                end else begin
                    e = exp_q.pop_front();
                    if ({eof, uop} !== e) begin
                        errors++;
                        $display("FAIL uop_stream[%0d] got eof=%0b uop=%h expected eof=%0b uop=%h",
                                 got_n, eof, uop, e[10], e[9:0]);
                    end
                end
                if (eof) begin
                    eofs++;
                    new_flow = 1'b1;
                end
            end
            if (eofs < n_eofs && mop_ready && op_q.size() > 0) begin
                mop = op_q.pop_front();
                mop_valid = 1'b1;
                if (new_flow) begin
                    start = cyc;
                    await_first = 1'b1;
                    new_flow = 1'b0;
                end
            end else begin
                mop_valid = 1'b0;
            end
            mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            if (eofs < n_eofs) begin
                tick();
                budget++;
            end
        end
        mop_valid = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (eofs != n_eofs) begin
            errors++;
            $display("FAIL flow_timeout got %0d eofs expected %0d", eofs, n_eofs);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_uops got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (uerr !== err_m) begin
            errors++;
            $display("FAIL uerr got %0b expected %0b", uerr, err_m);
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (mop_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b expected 1", mop_ready); end
        if (uop_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b expected 0", uop_valid); end
        if (eof !== 1'b0)       begin errors++; $display("FAIL rst_eof got %0b expected 0", eof); end
        if (uerr !== 1'b0)      begin errors++; $display("FAIL rst_uerr got %0b expected 0", uerr); end
        if (uop !== 10'd0)      begin errors++; $display("FAIL rst_uop got %h expected 0", uop); end
        if (uaddr !== 8'd0)     begin errors++; $display("FAIL rst_uaddr got %h expected 0", uaddr); end
        op_q.push_back(8'($urandom_range(1, 255)));
        model_run();
        run_ops(1, 1'b0);
    endtask

    task automatic test_basic();
        logic [9:0] pl [3];
        pl = '{10'h101, 10'h102, 10'h103};
        do_reset();
        tbl_write(1'b0, 8'h31, 8'd1);
        rom[1] = mk(F_NEXT, pl[0]);
        rom[2] = mk(F_NEXT, pl[1]);
        rom[3] = mk(F_EOF, pl[2]);
        mop = 8'h31; mop_valid = 1'b1;
        tick();
        mop_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                checks++;
                if (uaddr !== 8'(k + 1)) begin errors++; $display("FAIL basic_uaddr[%0d] got %0d expected %0d", k, uaddr, k + 1); end
            end
            checks++;
            if (uop_valid !== (k > 0)) begin errors++; $display("FAIL basic_valid[%0d] got %0b expected %0b", k, uop_valid, k > 0); end
            if (k > 0) begin
                checks++;
                if ({eof, uop} !== {k == 3, pl[k-1]}) begin
                    errors++;
                    $display("FAIL basic_uop[%0d] got eof=%0b uop=%h expected eof=%0b uop=%h", k, eof, uop, k == 3, pl[k-1]);
                end
            end
            if (k == 3) begin
                checks++;
                if (mop_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after_eof got %0b expected 1", mop_ready); end
            end
            tick();
        end
        checks++;
        if ({uop_valid, eof} !== 2'b00) begin errors++; $display("FAIL basic_idle got valid=%0b eof=%0b expected 0 0", uop_valid, eof); end
    endtask

    task automatic test_cb();
        do_reset();
        tbl_write(1'b0, 8'hCB, 8'd13);
        tbl_write(1'b1, 8'h7C, 8'd16);
        rom[13] = mk(F_JCB, 10'h0D0);
        rom[16] = mk(F_EOF, 10'h160);
        op_q = '{8'hCB, 8'h7C};
        model_run();
        run_ops(1, 1'b0);
        checks++;
        if (got_n != 2) begin errors++; $display("FAIL cb_uop_count got %0d expected 2", got_n); end
    endtask

    task automatic test_eof_if();
        do_reset();
        tbl_write(1'b0, 8'h40, 8'd19);
        rom[19] = mk(F_EOF_IF, 10'h190);
        rom[20] = mk(F_NEXT, 10'h200);
        rom[21] = mk(F_NEXT, 10'h210);
        rom[22] = mk(F_EOF, 10'h220);
        for (int c = 1; c >= 0; c--) begin
            cond = 1'(c);
            op_q.push_back(8'h40);
            model_run();
            run_ops(1, 1'b1);
            checks++;
            if (got_n != (c == 1 ? 1 : 4)) begin errors++; $display("FAIL eof_if_count cond=%0d got %0d expected %0d", c, got_n, c == 1 ? 1 : 4); end
        end
        cond = 1'b0;
    endtask

    task automatic test_wait();
        do_reset();
        tbl_write(1'b0, 8'h50, 8'd50);
        rom[50] = mk(F_WAIT, 10'h150);
        rom[51] = mk(F_EOF, 10'h151);
        mem_ack = 1'b0;
        mop = 8'h50; mop_valid = 1'b1;
        tick();
        mop_valid = 1'b0;
        checks++;
        if ({uaddr, uop_valid} !== {8'd50, 1'b0}) begin errors++; $display("FAIL wait_decode got addr=%0d valid=%0b expected 50 0", uaddr, uop_valid); end
        tick();
        checks++;
        if ({uaddr, uop_valid, eof, uop} !== {8'd50, 1'b1, 1'b0, 10'h150}) begin
            errors++; $display("FAIL wait_uop got addr=%0d valid=%0b eof=%0b uop=%h expected 50 1 0 150", uaddr, uop_valid, eof, uop);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({uaddr, uop_valid} !== {8'd50, 1'b0}) begin errors++; $display("FAIL wait_stall[%0d] got addr=%0d valid=%0b expected 50 0", k, uaddr, uop_valid); end
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({uaddr, uop_valid} !== {8'd51, 1'b0}) begin errors++; $display("FAIL wait_resume got addr=%0d valid=%0b expected 51 0", uaddr, uop_valid); end
        tick();
        checks++;
        if ({uop_valid, eof, uop} !== {1'b1, 1'b1, 10'h151}) begin errors++; $display("FAIL wait_tail got valid=%0b eof=%0b uop=%h expected 1 1 151", uop_valid, eof, uop); end
        tick();
        // Acknowledge already present: WAIT falls straight through.
        mem_ack = 1'b1;
        mop = 8'h50; mop_valid = 1'b1;
        tick();
        mop_valid = 1'b0;
        tick();
        checks++;
        if ({uaddr, uop_valid, uop} !== {8'd51, 1'b1, 10'h150}) begin errors++; $display("FAIL wait_ack_early got addr=%0d valid=%0b uop=%h expected 51 1 150", uaddr, uop_valid, uop); end
        tick();
        checks++;
        if ({uop_valid, eof, uop} !== {1'b1, 1'b1, 10'h151}) begin errors++; $display("FAIL wait_ack_early_tail got valid=%0b eof=%0b uop=%h expected 1 1 151", uop_valid, eof, uop); end
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_call();
        do_reset();
        tbl_write(1'b0, 8'h60, 8'd60);
        rom[60]  = mk(F_CALL, 10'd200);
        rom[200] = mk(F_CALL, 10'd210);
        rom[210] = mk(F_CALL, 10'd220);
        rom[220] = mk(F_RET, 10'h2DC);
        rom[201] = mk(F_RET, 10'h2C9);
        rom[61]  = mk(F_RET, 10'h23D);
        checks++;
        if (uerr !== 1'b0) begin errors++; $display("FAIL call_uerr_before got %0b expected 0", uerr); end
        op_q.push_back(8'h60);
        model_run();
        run_ops(1, 1'b0);
        checks++;
        if ({got_n == 6, uerr} !== 2'b11) begin errors++; $display("FAIL call_nest got count=%0d uerr=%0b expected 6 1", got_n, uerr); end
        do_reset();
        tbl_write(1'b0, 8'h70, 8'd70);
        rom[70] = mk(F_RET, 10'h170);
        op_q.push_back(8'h70);
        model_run();
        run_ops(1, 1'b0);
        checks++;
        if ({got_n == 1, uerr, mop_ready} !== 3'b111) begin errors++; $display("FAIL ret_empty got count=%0d uerr=%0b ready=%0b expected 1 1 1", got_n, uerr, mop_ready); end
    endtask

    task automatic test_reset_stall();
        do_reset();
        tbl_write(1'b0, 8'h80, 8'd80);
        rom[80] = mk(F_CALL, 10'd90);
        rom[90] = mk(F_WAIT, 10'h190);
        mem_ack = 1'b0;
        mop = 8'h80; mop_valid = 1'b1;
        tick();
        mop_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({uaddr, uop_valid} !== {8'd90, 1'b0}) begin errors++; $display("FAIL stall_entry got addr=%0d valid=%0b expected 90 0", uaddr, uop_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        checks++;
        if ({mop_ready, uop_valid, eof, uop, uaddr} !== {1'b1, 1'b0, 1'b0, 10'd0, 8'd0}) begin
            errors++; $display("FAIL stall_reset got ready=%0b valid=%0b eof=%0b uop=%h addr=%0d expected 1 0 0 0 0", mop_ready, uop_valid, eof, uop, uaddr);
        end
        // A RET at the cleared-table target only ends the flow if the stack really emptied.
        rom[0] = mk(F_RET, 10'h0AA);
        op_q.push_back(8'h80);
        model_run();
        run_ops(1, 1'b0);
        checks++;
        if (got_n != 1) begin errors++; $display("FAIL stall_reset_stack got %0d uops expected 1", got_n); end
        rom[0] = mk(F_EOF, 10'h3FF);
    endtask

    task automatic test_collision();
        do_reset();
        tbl_write(1'b0, 8'h22, 8'd100);
        rom[100] = mk(F_EOF, 10'h100);
        rom[110] = mk(F_EOF, 10'h110);
        mop = 8'h22; mop_valid = 1'b1;
        tbl_we = 1'b1; tbl_sel = 1'b0; tbl_addr = 8'h22; tbl_data = 8'd110;
        tick();
        mop_valid = 1'b0;
        prim_m[8'h22] = 8'd110;
        checks++;
        if (uaddr !== 8'd100) begin errors++; $display("FAIL collide_old_entry got %0d expected 100", uaddr); end
        tbl_addr = 8'h23;
        tick();
        tbl_we = 1'b0;
        prim_m[8'h23] = 8'd110;
        checks++;
        if ({uop_valid, eof, uop} !== {1'b1, 1'b1, 10'h100}) begin errors++; $display("FAIL collide_uop got valid=%0b eof=%0b uop=%h expected 1 1 100", uop_valid, eof, uop); end
        tick();
        op_q = '{8'h22, 8'h23};
        model_run();
        run_ops(2, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] picks [4];
        logic [7:0] op, start;
        int         len;
        picks = '{F_NEXT, F_EOF_IF, F_WAIT, F_BAD};
        do_reset();
        for (int it = 0; it < 30; it++) begin
            cond = 1'($urandom_range(0, 1));
            for (int f = 0; f < 2; f++) begin
                op    = 8'($urandom);
                start = (it % 5 == 0) ? 8'd253 : 8'($urandom);
                len   = $urandom_range(0, 5);
                tbl_write(1'b0, op, start);
                for (int j = 0; j < len; j++)
                    rom[8'(start + 8'(j))] = mk(picks[$urandom_range(0, 3)], 10'($urandom));
                rom[8'(start + 8'(len))] = mk(F_EOF, 10'($urandom));
                op_q.push_back(op);
            end
            model_run();
            run_ops(2, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; mop = 8'd0; mop_valid = 1'b0; cond = 1'b0; mem_ack = 1'b0;
        tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = 8'd0; tbl_data = 8'd0;
        for (int i = 0; i < 256; i++) rom[i] = mk(F_EOF, 10'(i));
        rom[0] = mk(F_EOF, 10'h3FF);
        test_reset();
        test_basic();
        test_cb();
        test_eof_if();
        test_wait();
        test_call();
        test_reset_stall();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
Parametrised microcode sequencer for the dzcpu core. It replaces fixed opcode-to-flow case tables with two run-time loadable dispatch tables (primary and 0xCB-prefixed) and adds a micro-PC, micro-subroutine stack, memory-wait stalls and conditional flow termination. It sits between the opcode fetch path and an external microcode ROM, and it emits one registered micro-op payload per executed microword to the datapath.

Parameters:
UADDR_W, 8, micro-address width; ROM depth is 2**UADDR_W.
PAYLOAD_W, 10, micro-op payload width passed to the datapath.
FLOW_W, 3, flow-control field width, fixed at 3 for this revision.
STACK_DEPTH, 2, micro-return stack entries, minimum 1.

Ports:
iClock  in  1  clock.
iReset  in  1  synchronous, active-high reset.
iMop  in  8  opcode byte from fetch.
iMopValid  in  1  iMop valid.
oMopReady  out  1  sequencer accepts an opcode byte this cycle.
oUaddr  out  UADDR_W  address to the microcode ROM (combinational ROM).
iUword  in  FLOW_W+PAYLOAD_W  ROM data = {flow, payload}; payload[UADDR_W-1:0] doubles as CALL target.
iCond  in  1  datapath condition for EOF_IF.
iMemAck  in  1  memory transaction complete.
iTblWe  in  1  dispatch table write strobe.
iTblSel  in  1  0 = primary table, 1 = CB table.
iTblAddr  in  8  table index.
iTblData  in  UADDR_W  flow start address.
oUop  out  PAYLOAD_W  registered payload.
oUopValid  out  1  oUop valid for one cycle.
oEof  out  1  pulses with the last uop of a flow.
oUerr  out  1  sticky error flag.

Behaviour:
- Reset: state FETCH; uPC = 0; stack pointer = 0; oUop = 0; oUopValid = 0; oEof = 0; oUerr = 0. Both dispatch tables are cleared to 0, which points every opcode at the generic one-byte flow at address 0. Reset mid-flow abandons the flow immediately.
- States:
  - FETCH: oMopReady = 1. On iMopValid, uPC <= primary[iMop], then go to RUN.
  - RUN: oUaddr = uPC. The ROM word is decoded the same cycle. Payload is registered to oUop, with oUopValid = 1 the next cycle.
  - CBWAIT: oMopReady = 1. On iMopValid, uPC <= cb[iMop], then go to RUN.
  - STALL: holds uPC. No oUopValid. Returns to RUN at uPC+1 on iMemAck.
- Flow codes, decoded in RUN:
  - 0 NEXT: uPC + 1.
  - 1 EOF: go to FETCH; oEof pulses with that uop.
  - 2 EOF_IF: if iCond = 1, behave as EOF; else NEXT.
  - 3 JCB: issue the uop, then go to CBWAIT.
  - 4 CALL: push uPC+1; uPC <= target. The payload is still issued.
  - 5 RET: pop into uPC.
  - 6 WAIT: issue the uop, then go to STALL. If iMemAck is already 1 in the same cycle, behave as NEXT.
  - 7: behave as NEXT and set oUerr.
- Latency: opcode accepted at cycle N; first oUopValid at N+2. Back-to-back flows issue one uop per cycle with no bubble besides FETCH.
- uPC wraps modulo 2**UADDR_W on NEXT.
- CALL with stack full: push dropped, oUerr set, jump still taken. RET with stack empty: oUerr set, flow terminated as EOF.
- Table write while in FETCH and iMopValid to the same index in the same cycle: dispatch uses the old entry; the write lands.
- Table writes are accepted in any state.
- oUerr clears only on iReset.

Optional Feature:
DZCPU_USEQ_PERF_EN:
- Defined: adds output oFlowCycles (16 bits). It holds the number of cycles from opcode acceptance to the EOF uop of the last completed flow, inclusive, stall cycles included. The count saturates at 16'hFFFF and updates on the oEof cycle. Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Write primary[0x31] = 8'd1; ROM[1..3] = NEXT, NEXT, EOF; send 0x31 -> oUaddr 1, 2, 3; oUopValid for 3 cycles starting N+2; oEof on the 3rd; oMopReady high the following cycle.
- primary[0xCB] = 13 with ROM[13] = JCB; cb[0x7C] = 16 with ROM[16] = EOF; send 0xCB then 0x7C -> two uops, oEof on payload of ROM[16].
- EOF_IF at ROM[19]: iCond = 1 -> flow ends at 19. iCond = 0 -> uops 20, 21, 22 follow, oEof at 22.
- ROM[50] = WAIT, iMemAck held low 4 cycles then pulsed -> oUaddr holds 50, no oUopValid for 4 cycles; resumes at 51.
- CALL to 200 with STACK_DEPTH = 2, nested 3 deep -> oUerr = 1 on the third CALL. RET on empty stack -> oUerr stays 1, return to FETCH.
- Assert iReset during STALL -> next cycle oMopReady = 1, oUop = 0, stack empty, tables all 0.
